// File: rtl/alu_cntrl_pkg.sv
// Shared types for the registered ALU control stage: ALU op encodings,
// opcode/funct constants, FSM states and the decoded control bundle.
package alu_cntrl_pkg;

    typedef enum logic [2:0] {
        ALU_ROL = 3'b000,
        ALU_SLL = 3'b001,
        ALU_ROR = 3'b010,
        ALU_SRL = 3'b011,
        ALU_ADD = 3'b100,
        ALU_OR  = 3'b101,
        ALU_XOR = 3'b110,
        ALU_AND = 3'b111
    } aluOp_t;

    // Opcodes
    localparam logic [4:0] OPC_ADDI  = 5'b01000;
    localparam logic [4:0] OPC_SUBI  = 5'b01001;
    localparam logic [4:0] OPC_XORI  = 5'b01010;
    localparam logic [4:0] OPC_ANDNI = 5'b01011;
    localparam logic [4:0] OPC_ST    = 5'b10000;
    localparam logic [4:0] OPC_LD    = 5'b10001;
    localparam logic [4:0] OPC_STU   = 5'b10011;
    localparam logic [4:0] OPC_ROLI  = 5'b10100;
    localparam logic [4:0] OPC_SLLI  = 5'b10101;
    localparam logic [4:0] OPC_RORI  = 5'b10110;
    localparam logic [4:0] OPC_SRLI  = 5'b10111;
    localparam logic [4:0] OPC_MUL   = 5'b11000;
    localparam logic [4:0] OPC_SHIFT = 5'b11010;
    localparam logic [4:0] OPC_RTYPE = 5'b11011;
    localparam logic [4:0] OPC_SEQ   = 5'b11100;
    localparam logic [4:0] OPC_SLT   = 5'b11101;
    localparam logic [4:0] OPC_SLE   = 5'b11110;
    localparam logic [4:0] OPC_SCO   = 5'b11111;

    // R-type function field
    localparam logic [1:0] FN_ADD  = 2'b00;
    localparam logic [1:0] FN_SUB  = 2'b01;
    localparam logic [1:0] FN_XOR  = 2'b10;
    localparam logic [1:0] FN_ANDN = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    typedef struct packed {
        aluOp_t aluOp;
        logic   invA;
        logic   invB;
        logic   Cin;
        logic   sign;
        logic   rorSel;
        logic   noAlu;
    } ctrl_t;

    // Shift/rotate selector (funct or opcode low bits) to controls.
    function automatic ctrl_t shiftCtrl(input logic [1:0] sel);
        ctrl_t c;
        c        = '0;
        c.aluOp  = aluOp_t'({1'b0, sel});
        c.rorSel = (sel == 2'b10);
        return c;
    endfunction

endpackage

// File: rtl/alu_cntrl_seq_if.sv
// ID -> EX handshake and ALU control bus of the registered control stage.
import alu_cntrl_pkg::*;

interface alu_cntrl_seq_if;
    logic       inValid;
    logic       inReady;
    logic [4:0] opCode;
    logic [1:0] funct;
    logic       stall;
    logic       flush;
    logic       outValid;
    aluOp_t     aluOp;
    logic       invA;
    logic       invB;
    logic       Cin;
    logic       sign;
    logic       rorSel;
    logic       noAlu;
    logic       mulStep;
    logic       mulFirst;
    logic       mulLast;

    // Driver side (ID stage / pipeline control).
    modport master (
        output inValid, opCode, funct, stall, flush,
        input  inReady, outValid, aluOp, invA, invB, Cin, sign, rorSel, noAlu,
               mulStep, mulFirst, mulLast
    );

    // Control stage side.
    modport slave (
        input  inValid, opCode, funct, stall, flush,
        output inReady, outValid, aluOp, invA, invB, Cin, sign, rorSel, noAlu,
               mulStep, mulFirst, mulLast
    );
endinterface

// File: rtl/alu_cntrl_dec.sv
// Pure combinational decode of opCode/funct into the ALU control bundle.
import alu_cntrl_pkg::*;

module alu_cntrl_dec #(
    parameter bit MULT_EN = 1'b1
) (
    input  logic [4:0] opCode,
    input  logic [1:0] funct,
    output ctrl_t      ctrl,
    output logic       isMul
);

    // Decode table; anything not listed is a non-ALU instruction.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        ctrl       = '0;
        ctrl.aluOp = ALU_ADD;
        isMul      = 1'b0;
        case (opCode)
            OPC_RTYPE: begin
                case (funct)
                    FN_ADD:  ctrl.sign = 1'b1;
                    FN_SUB:  begin
                        ctrl.invA = 1'b1;
                        ctrl.Cin  = 1'b1;
                        ctrl.sign = 1'b1;
                    end
                    FN_XOR:  ctrl.aluOp = ALU_XOR;
                    default: begin
                        ctrl.aluOp = ALU_AND;
                        ctrl.invB  = 1'b1;
                    end
                endcase
            end
            OPC_ADDI, OPC_ST, OPC_LD, OPC_STU: ctrl.sign = 1'b1;
            OPC_SUBI: begin
                // B - A: invert A and add one.
                ctrl.invA = 1'b1;
                ctrl.Cin  = 1'b1;
                ctrl.sign = 1'b1;
            end
            OPC_XORI:  ctrl.aluOp = ALU_XOR;
            OPC_ANDNI: begin
                ctrl.aluOp = ALU_AND;
                ctrl.invB  = 1'b1;
            end
            OPC_SEQ, OPC_SLT, OPC_SLE: begin
                // Compares compute A - B.
                ctrl.invB = 1'b1;
                ctrl.Cin  = 1'b1;
                ctrl.sign = 1'b1;
            end
            OPC_SCO:   ctrl.sign = 1'b0;
            OPC_SHIFT: ctrl = shiftCtrl(funct);
            OPC_ROLI, OPC_SLLI, OPC_RORI, OPC_SRLI: ctrl = shiftCtrl(opCode[1:0]);
            OPC_MUL: begin
                if (MULT_EN) begin
                    isMul = 1'b1;
                end else begin
                    ctrl.noAlu = 1'b1;
                end
            end
            default: ctrl.noAlu = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_cntrl_seq.sv
// Registered ALU control stage between ID and EX: decode, EX register,
// valid/ready handshake with stall/flush, and a multi-cycle MUL sequencer.
import alu_cntrl_pkg::*;

module alu_cntrl_seq #(
    parameter int N       = 16,
    parameter bit MULT_EN = 1'b1,
    parameter int ITER    = N,
    parameter int CNT_W   = $clog2(ITER)
) (
    input logic           clk,
    input logic           rst,
    alu_cntrl_seq_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

    state_t           state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    ctrl_t            ctrlQ, ctrlNext;
    logic             outValidQ, outValidNext;
    logic             mulStepQ, mulStepNext;
    logic             mulFirstQ, mulFirstNext;
    logic             mulLastQ, mulLastNext;

    ctrl_t            decCtrl;
    logic             decIsMul;
    logic             accept;

    alu_cntrl_dec #(.MULT_EN(MULT_EN)) uDec (
        .opCode (bus.opCode),
        .funct  (bus.funct),
        .ctrl   (decCtrl),
        .isMul  (decIsMul)
    );

    // Ready only when idle and not held; flush kills the accept that cycle.
    assign bus.inReady = !bus.stall && (state == ST_IDLE);
    assign accept      = bus.inValid && bus.inReady && !bus.flush;

    // Next-state and next-output logic; flush beats stall, stall holds everything.
    always_comb begin
        stateNext    = state;
        cntNext      = cnt;
        ctrlNext     = ctrlQ;
        outValidNext = outValidQ;
        mulStepNext  = mulStepQ;
        mulFirstNext = mulFirstQ;
        mulLastNext  = mulLastQ;
        if (bus.flush) begin
            stateNext    = ST_IDLE;
            cntNext      = '0;
            ctrlNext     = '0;
            outValidNext = 1'b0;
            mulStepNext  = 1'b0;
            mulFirstNext = 1'b0;
            mulLastNext  = 1'b0;
        end else if (!bus.stall) begin
            case (state)
                ST_IDLE: begin
                    cntNext      = '0;
                    ctrlNext     = '0;
                    outValidNext = 1'b0;
                    mulStepNext  = 1'b0;
                    mulFirstNext = 1'b0;
                    mulLastNext  = 1'b0;
                    if (accept) begin
                        ctrlNext     = decCtrl;
                        outValidNext = 1'b1;
                        if (decIsMul) begin
                            stateNext    = ST_MUL;
                            mulStepNext  = 1'b1;
                            mulFirstNext = 1'b1;
                        end
                    end
                end
                default: begin
                    if (cnt == LAST) begin
                        // Final step done: one bubble before the next accept.
                        stateNext    = ST_IDLE;
                        cntNext      = '0;
                        ctrlNext     = '0;
                        outValidNext = 1'b0;
                        mulStepNext  = 1'b0;
                        mulFirstNext = 1'b0;
                        mulLastNext  = 1'b0;
                    end else begin
                        cntNext      = cnt + CNT_W'(1);
                        mulFirstNext = 1'b0;
                        mulLastNext  = (cntNext == LAST);
                    end
                end
            endcase
        end
    end

    // EX register, FSM state and iteration counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            ctrlQ     <= '0;
            outValidQ <= 1'b0;
            mulStepQ  <= 1'b0;
            mulFirstQ <= 1'b0;
            mulLastQ  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state     <= stateNext;
            cnt       <= cntNext;
            ctrlQ     <= ctrlNext;
            outValidQ <= outValidNext;
            mulStepQ  <= mulStepNext;
            mulFirstQ <= mulFirstNext;
            mulLastQ  <= mulLastNext;
        end
    end

    assign bus.outValid = outValidQ;
    assign bus.aluOp    = ctrlQ.aluOp;
    assign bus.invA     = ctrlQ.invA;
    assign bus.invB     = ctrlQ.invB;
    assign bus.Cin      = ctrlQ.Cin;
    assign bus.sign     = ctrlQ.sign;
    assign bus.rorSel   = ctrlQ.rorSel;
    assign bus.noAlu    = ctrlQ.noAlu;
    assign bus.mulStep  = mulStepQ;
    assign bus.mulFirst = mulFirstQ;
    assign bus.mulLast  = mulLastQ;

endmodule

// File: tb/tb_alu_cntrl_seq.sv
// Self-checking bench for alu_cntrl_seq: directed scenarios plus random
// traffic, compared against a behavioural model of the control stage.
`timescale 1ns/1ps

module tb_alu_cntrl_seq;

    typedef struct packed {
        logic       outValid;
        logic [2:0] aluOp;
        logic       invA;
        logic       invB;
        logic       cin;
        logic       sign;
        logic       rorSel;
        logic       noAlu;
        logic       mulStep;
        logic       mulFirst;
        logic       mulLast;
    } exp_t;

    // Model: busy while a MUL runs, k = number of the step now shown (1..iter).
    typedef struct {
        bit   busy;
        int   k;
        exp_t o;
    } model_t;

    localparam int ITER0 = 16;
    localparam int ITER1 = 4;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    model_t m0;
    model_t m1;

    alu_cntrl_seq_if bus0 ();
    alu_cntrl_seq_if bus1 ();

    alu_cntrl_seq #(.N(16), .MULT_EN(1'b1), .ITER(ITER0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    alu_cntrl_seq #(.N(16), .MULT_EN(1'b0), .ITER(ITER1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference decode written straight from the instruction table.
    function automatic exp_t decodeRef(input logic [4:0] op, input logic [1:0] fn,
                                       input bit multEn, output bit isMul);
        exp_t       e;
        logic [1:0] sel;
        e          = '0;
        e.outValid = 1'b1;
        e.aluOp    = 3'b100;
        isMul      = 1'b0;
        if (op == 5'b11011) begin
            if (fn == 2'd0) e.sign = 1'b1;
            else if (fn == 2'd1) begin e.invA = 1'b1; e.cin = 1'b1; e.sign = 1'b1; end
            else if (fn == 2'd2) e.aluOp = 3'b110;
            else begin e.aluOp = 3'b111; e.invB = 1'b1; end
        end else if (op == 5'b01000 || op == 5'b10000 || op == 5'b10001 || op == 5'b10011) begin
            e.sign = 1'b1;
        end else if (op == 5'b01001) begin
            e.invA = 1'b1; e.cin = 1'b1; e.sign = 1'b1;
        end else if (op == 5'b01010) begin
            e.aluOp = 3'b110;
        end else if (op == 5'b01011) begin
            e.aluOp = 3'b111; e.invB = 1'b1;
        end else if (op == 5'b11100 || op == 5'b11101 || op == 5'b11110) begin
            e.invB = 1'b1; e.cin = 1'b1; e.sign = 1'b1;
        end else if (op == 5'b11111) begin
            e.sign = 1'b0;
        end else if (op == 5'b11010 || (op >= 5'b10100 && op <= 5'b10111)) begin
            sel = (op == 5'b11010) ? fn : op[1:0];
            case (sel)
                2'd0: e.aluOp = 3'b000;
                2'd1: e.aluOp = 3'b001;
                2'd2: begin e.aluOp = 3'b010; e.rorSel = 1'b1; end
                default: e.aluOp = 3'b011;
            endcase
        end else if (op == 5'b11000 && multEn) begin
            isMul = 1'b1;
        end else begin
            e.noAlu = 1'b1;
        end
        return e;
    endfunction

    function automatic model_t modelStep(input model_t m, input bit multEn, input int iter,
                                         input bit v, input logic [4:0] op, input logic [1:0] fn,
                                         input bit st, input bit fl);
        model_t r;
        bit     isMul;
        exp_t   e;
        r = m;
        if (fl) begin
            r = '{busy: 1'b0, k: 0, o: '0};
        end else if (!st) begin
            if (m.busy) begin
                if (m.k == iter) begin
                    r = '{busy: 1'b0, k: 0, o: '0};
                end else begin
                    r.k          = m.k + 1;
                    r.o.mulFirst = 1'b0;
                    r.o.mulLast  = (r.k == iter);
                end
            end else if (v) begin
                e = decodeRef(op, fn, multEn, isMul);
                if (isMul) begin
                    e.mulStep  = 1'b1;
                    e.mulFirst = 1'b1;
                    r = '{busy: 1'b1, k: 1, o: e};
                end else begin
                    r = '{busy: 1'b0, k: 0, o: e};
                end
            end else begin
                r = '{busy: 1'b0, k: 0, o: '0};
            end
        end
        return r;
    endfunction

    function automatic exp_t grab0();
        return {bus0.outValid, bus0.aluOp, bus0.invA, bus0.invB, bus0.Cin, bus0.sign,
                bus0.rorSel, bus0.noAlu, bus0.mulStep, bus0.mulFirst, bus0.mulLast};
    endfunction

    function automatic exp_t grab1();
        return {bus1.outValid, bus1.aluOp, bus1.invA, bus1.invB, bus1.Cin, bus1.sign,
                bus1.rorSel, bus1.noAlu, bus1.mulStep, bus1.mulFirst, bus1.mulLast};
    endfunction

    task automatic cmpOut(input string name, input exp_t got, input exp_t exp);
        check({name, ".outValid"}, got.outValid, exp.outValid);
        check({name, ".aluOp"}, got.aluOp, exp.aluOp);
        check({name, ".flags"}, {got.invA, got.invB, got.cin, got.sign, got.rorSel, got.noAlu},
              {exp.invA, exp.invB, exp.cin, exp.sign, exp.rorSel, exp.noAlu});
        check({name, ".mul"}, {got.mulStep, got.mulFirst, got.mulLast},
              {exp.mulStep, exp.mulFirst, exp.mulLast});
    endtask

    task automatic setIn(input bit v, input logic [4:0] op, input logic [1:0] fn,
                         input bit st, input bit fl);
        bus0.inValid = v;  bus1.inValid = v;
        bus0.opCode  = op; bus1.opCode  = op;
        bus0.funct   = fn; bus1.funct   = fn;
        bus0.stall   = st; bus1.stall   = st;
        bus0.flush   = fl; bus1.flush   = fl;
    endtask

    // One clock: drive inputs, check ready, clock both models, check outputs.
    task automatic cycle(input bit v, input logic [4:0] op, input logic [1:0] fn,
                         input bit st, input bit fl);
        setIn(v, op, fn, st, fl);
        #1;
        check("d0.inReady", bus0.inReady, !st && !m0.busy);
        check("d1.inReady", bus1.inReady, !st && !m1.busy);
        @(posedge clk);
        m0 = modelStep(m0, 1'b1, ITER0, v, op, fn, st, fl);
        m1 = modelStep(m1, 1'b0, ITER1, v, op, fn, st, fl);
        #1;
        cmpOut("d0", grab0(), m0.o);
        cmpOut("d1", grab1(), m1.o);
    endtask

    task automatic modelReset();
        m0 = '{busy: 1'b0, k: 0, o: '0};
        m1 = '{busy: 1'b0, k: 0, o: '0};
    endtask

    // Run one MUL; optionally stall after 'runBefore' steps. Returns cycle index of mulLast.
    task automatic runMul(input int runBefore, input int stallLen, output int lastIdx,
                          output int firstCnt, output int notReady);
        int idx;
        lastIdx  = -1;
        firstCnt = 0;
        notReady = 0;
        cycle(1'b1, 5'b11000, 2'd0, 1'b0, 1'b0);
        idx = 1;
        if (bus0.mulFirst) firstCnt++;
        if (!bus0.inReady) notReady++;
        for (int i = 0; i < 40 && lastIdx < 0; i++) begin
            if (bus0.mulLast) lastIdx = idx;
            else begin
                cycle(1'b1, 5'($urandom), 2'($urandom),
                      (i >= runBefore) && (i < runBefore + stallLen), 1'b0);
                idx++;
                if (bus0.mulFirst) firstCnt++;
                if (!bus0.inReady && bus0.outValid) notReady++;
            end
        end
    endtask

    initial begin
        int lastIdx;
        int firstCnt;
        int notReady;
        total = 0;
        bad   = 0;
        modelReset();
        rst = 1'b1;
        setIn(1'b0, 5'd0, 2'd0, 1'b0, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        cmpOut("rst.d0", grab0(), '0);
        check("rst.inReady", bus0.inReady, 1'b1);
        bus0.stall = 1'b1;
        #1;
        check("rst.inReadyStall", bus0.inReady, 1'b0);
        bus0.stall = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // SUB then idle
        cycle(1'b1, 5'b11011, 2'b01, 1'b0, 1'b0);
        check("sub.ctl", {bus0.outValid, bus0.aluOp, bus0.invA, bus0.Cin, bus0.sign, bus0.invB},
              {1'b1, 3'b100, 1'b1, 1'b1, 1'b1, 1'b0});
        cycle(1'b0, 5'd0, 2'd0, 1'b0, 1'b0);
        check("idle.outValid", bus0.outValid, 1'b0);

        // ROR then SRLI back-to-back
        cycle(1'b1, 5'b11010, 2'b10, 1'b0, 1'b0);
        check("ror", {bus0.aluOp, bus0.rorSel}, {3'b010, 1'b1});
        cycle(1'b1, 5'b10111, 2'b00, 1'b0, 1'b0);
        check("srli", {bus0.aluOp, bus0.rorSel}, {3'b011, 1'b0});
        cycle(1'b0, 5'd0, 2'd0, 1'b0, 1'b0);

        // Full MUL
        runMul(100, 0, lastIdx, firstCnt, notReady);
        check("mul.lastIdx", lastIdx, 16);
        check("mul.firstCnt", firstCnt, 1);
        check("mul.notReady", notReady, 16);
        cycle(1'b0, 5'd0, 2'd0, 1'b0, 1'b0);
        check("mul.bubble", {bus0.outValid, bus0.inReady}, {1'b0, 1'b1});

        // MUL stalled 3 cycles at cnt=5
        runMul(5, 3, lastIdx, firstCnt, notReady);
        check("mulStall.lastIdx", lastIdx, 19);
        cycle(1'b0, 5'd0, 2'd0, 1'b0, 1'b0);

        // Flush with stall at cnt=7; MULT_EN=0 instance decodes 11000 as noAlu
        cycle(1'b1, 5'b11000, 2'd0, 1'b0, 1'b0);
        check("noMul.d1", {bus1.outValid, bus1.noAlu, bus1.aluOp, bus1.mulStep}, {1'b1, 1'b1, 3'b100, 1'b0});
        repeat (7) cycle(1'b0, 5'd0, 2'd0, 1'b0, 1'b0);
        cycle(1'b1, 5'b11011, 2'd0, 1'b1, 1'b1);
        setIn(1'b0, 5'd0, 2'd0, 1'b0, 1'b0);
        #1;
        check("flush.state", {bus0.outValid, bus0.mulStep, bus0.inReady}, {1'b0, 1'b0, 1'b1});

        // Async reset mid-MUL
        cycle(1'b1, 5'b11000, 2'd0, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 5'd0, 2'd0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        cmpOut("asyncRst.d0", grab0(), '0);
        check("asyncRst.inReady", bus0.inReady, 1'b1);
        modelReset();
        #2;
        rst = 1'b0;

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 9) < 7,
                  ($urandom_range(0, 3) == 0) ? 5'b11000 : 5'($urandom),
                  2'($urandom),
                  $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
